mux_slot_sequencer: RTL and testbench

- Control stage directly upstream of the 8-bit 4:1 select mux in the frequency-multiplier datapath.
- Drives the mux select lines sel0/sel1 round-robin over a programmable set of enabled slots, holding each slot for a programmable dwell.
- Captures the mux output at the end of each dwell and presents it downstream as a one-cycle strobed sample tagged with its slot index.

---
 rtl/mux_seq_pkg.sv | 14 +
 rtl/slot_rr_next.sv | 30 +++
 rtl/mux_slot_sequencer.sv | 103 ++++++++++
 tb/tb_mux_slot_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux slot sequencer.
package mux_seq_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  typedef logic [1:0] slot_t;

  localparam int    NUM_SLOTS = 4;
  localparam slot_t SLOT_IN0  = 2'd0;
  localparam slot_t SLOT_IN1  = 2'd1;
  localparam slot_t SLOT_IN2  = 2'd2;
  localparam slot_t SLOT_IN3  = 2'd3;

endpackage

// File: rtl/slot_rr_next.sv
// Round-robin slot finder: the next enabled slot above the current one
// (wrapping, so a lone enabled slot selects itself), plus the lowest set
// bit of the mask being offered at start.
module slot_rr_next
  import mux_seq_pkg::*;
(
  input  slot_t                cur,
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [NUM_SLOTS-1:0] start_mask,
  output slot_t                nxt,
  output slot_t                first
);

  // Scan offsets high to low so the nearest enabled slot overwrites farther ones.
  always_comb begin
    nxt = cur;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      if (mask[cur + slot_t'(k)]) nxt = cur + slot_t'(k);
    end
  end

  // Scan slots high to low so the lowest set bit wins.
  always_comb begin
    first = SLOT_IN0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (start_mask[k]) first = slot_t'(k);
    end
  end

endmodule

// File: rtl/mux_slot_sequencer.sv
// Drives the 4:1 mux selects round-robin over the enabled slots, holds each
// slot for dwell+1 cycles and captures the mux output on the last cycle.
module mux_slot_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [DATA_W-1:0]    mux_out,
  output logic                 sel0,
  output logic                 sel1,
  output logic [DATA_W-1:0]    sample_data,
  output logic [1:0]           sample_slot,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 err
);

  state_t               state;
  slot_t                slot;
  slot_t                slot_nxt;
  slot_t                slot_first;
  logic [NUM_SLOTS-1:0] mask_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt;
  logic                 stop_pending;

  slot_rr_next u_rr (
    .cur        (slot),
    .mask       (mask_q),
    .start_mask (slot_mask),
    .nxt        (slot_nxt),
    .first      (slot_first)
  );

  // Selects come straight off the slot register.
  assign sel0 = slot[1];
  assign sel1 = slot[0];

  // Sequencer FSM: dwell counting, slot advance, sample capture and halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      slot         <= SLOT_IN0;
      mask_q       <= '0;
      dwell_q      <= '0;
      cnt          <= '0;
      stop_pending <= 1'b0;
      sample_data  <= '0;
      sample_slot  <= SLOT_IN0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (|slot_mask) begin
              mask_q       <= slot_mask;
              dwell_q      <= dwell;
              cnt          <= dwell;
              slot         <= slot_first;
              busy         <= 1'b1;
              // A stop arriving with the start limits the run to one slot.
              stop_pending <= stop;
              state        <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (stop) stop_pending <= 1'b1;
          end else begin
            sample_data  <= mux_out;
            sample_slot  <= slot;
            sample_valid <= 1'b1;
            if (stop_pending || stop) begin
              state        <= IDLE;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              slot <= slot_nxt;
              cnt  <= dwell_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_slot_sequencer.sv
// Directed bench for mux_slot_sequencer with a sample scoreboard.
module tb_mux_slot_sequencer;

  typedef struct packed {
    logic [1:0] slot;
    logic [7:0] data;
  } smp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] slot_mask = 4'd0;
  logic [7:0] dwell = 8'd0;
  logic [7:0] mux_out;
  logic       sel0, sel1;
  logic [7:0] sample_data;
  logic [1:0] sample_slot;
  logic       sample_valid, busy, err;

  int   vectors = 0;
  int   errs    = 0;
  smp_t exp_q[$];

  always #5 clk = ~clk;

  // Mux model: input n carries 0x10+n.
  assign mux_out = 8'h10 + {6'd0, sel0, sel1};

  mux_slot_sequencer #(.DATA_W(8), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .slot_mask(slot_mask), .dwell(dwell), .mux_out(mux_out),
    .sel0(sel0), .sel1(sel1), .sample_data(sample_data),
    .sample_slot(sample_slot), .sample_valid(sample_valid),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s);
    smp_t e;
    e.slot = s;
    e.data = 8'h10 + {6'd0, s};
    exp_q.push_back(e);
  endtask

  // Scoreboard: every strobed sample must match the oldest expectation.
  always @(negedge clk) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", {22'd0, sample_slot, sample_data}, 32'hFFFF_FFFF);
      end else begin
        smp_t e;
        e = exp_q.pop_front();
        chk("sample_slot", {30'd0, sample_slot}, {30'd0, e.slot});
        chk("sample_data", {24'd0, sample_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_sel",   {30'd0, sel0, sel1}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_data",  {24'd0, sample_data}, 32'd0);
    chk("rst_slot",  {30'd0, sample_slot}, 32'd0);

    // Stop in IDLE is ignored
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);

    // Full mask, dwell 0: slot changes every cycle
    slot_mask = 4'b1111; dwell = 8'd0; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_sel",  {30'd0, sel0, sel1}, i % 4);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      push(2'(i % 4));
      if (i == 7) stop = 1'b1;
      step(); stop = 1'b0;
    end
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_sel_hold", {30'd0, sel0, sel1}, 32'd3);
    step(); step();

    // Sparse mask 0101, dwell 2; stop during the second slot-0 dwell
    slot_mask = 4'b0101; dwell = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    slot_mask = 4'b1111; dwell = 8'd0;   // must not affect the running sequence
    for (int i = 0; i < 9; i++) begin
      chk("t2_sel", {30'd0, sel0, sel1}, ((i / 3) % 2 == 1) ? 32'd2 : 32'd0);
      chk("t2_busy", {31'd0, busy}, 32'd1);
      if (i % 3 == 2) push(((i / 3) % 2 == 1) ? 2'd2 : 2'd0);
      if (i == 6) stop = 1'b1;
      if (i == 1) start = 1'b1;          // start in RUN is ignored
      step(); stop = 1'b0; start = 1'b0;
    end
    chk("t2_busy_end", {31'd0, busy}, 32'd0);
    chk("t2_sel_hold", {30'd0, sel0, sel1}, 32'd0);
    step();

    // Empty mask: one-cycle error, no run
    slot_mask = 4'b0000; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_err",  {31'd0, err}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    step();
    chk("t3_err_clr", {31'd0, err}, 32'd0);
    chk("t3_busy2",   {31'd0, busy}, 32'd0);
    step();

    // Mid-dwell stop on slot 1, dwell 3
    slot_mask = 4'b0010; dwell = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_sel",  {30'd0, sel0, sel1}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd1);
      if (i == 1) stop = 1'b1;
      if (i == 3) push(2'd1);
      step(); stop = 1'b0;
    end
    chk("t4_busy_fall", {31'd0, busy}, 32'd0);
    chk("t4_valid",     {31'd0, sample_valid}, 32'd1);
    chk("t4_sel_hold",  {30'd0, sel0, sel1}, 32'd1);
    step();

    // Start and stop together: exactly one slot-3 sample
    slot_mask = 4'b1000; dwell = 8'd1; start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t5_sel",  {30'd0, sel0, sel1}, 32'd3);
      chk("t5_busy", {31'd0, busy}, 32'd1);
      if (i == 1) push(2'd3);
      step();
    end
    chk("t5_busy_end", {31'd0, busy}, 32'd0);
    step(); step(); step();
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // Reset mid-run at cnt=1: in-flight sample discarded
    slot_mask = 4'b1110; dwell = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    chk("t6_sel", {30'd0, sel0, sel1}, 32'd1);
    step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("t6_sel",   {30'd0, sel0, sel1}, 32'd0);
    chk("t6_busy",  {31'd0, busy}, 32'd0);
    chk("t6_valid", {31'd0, sample_valid}, 32'd0);
    chk("t6_err",   {31'd0, err}, 32'd0);
    chk("t6_data",  {24'd0, sample_data}, 32'd0);
    chk("t6_slot",  {30'd0, sample_slot}, 32'd0);
    step(); step(); step();
    chk("t6_quiet", {31'd0, busy}, 32'd0);

    // Fresh start after reset
    slot_mask = 4'b0100; dwell = 8'd1; start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    chk("t7_sel", {30'd0, sel0, sel1}, 32'd2);
    push(2'd2);
    step();
    chk("t7_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t7_valid", {31'd0, sample_valid}, 32'd1);
    chk("t7_busy_end", {31'd0, busy}, 32'd0);
    step(); step();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
